// File: rtl/alu_mem_prog_if.sv
// Bus bundle for alu_mem_prog: ALU operands, data-memory ports and program counter.
// The master drives requests; the slave (the design) returns registered results.
interface alu_mem_prog_if #(
    parameter int DMEM_AW = 7,
    parameter int PMEM_AW = 10
);
    logic [3:0]         alu_op;
    logic [15:0]        operA;
    logic [15:0]        operB;
    logic [15:0]        alu_out;
    logic               we;
    logic [15:0]        data_in;
    logic [DMEM_AW-1:0] w_addr;
    logic [DMEM_AW-1:0] r_addr;
    logic [15:0]        data_out;
    logic [PMEM_AW-1:0] pc;
    logic [31:0]        instruction;

    modport master (
        output alu_op, operA, operB, we, data_in, w_addr, r_addr, pc,
        input  alu_out, data_out, instruction
    );

    modport slave (
        input  alu_op, operA, operB, we, data_in, w_addr, r_addr, pc,
        output alu_out, data_out, instruction
    );
endinterface

// File: rtl/alu_mem_prog.sv
// Registered 16-bit ALU, 16-bit data RAM and 32-bit program ROM.
// Define ALU_MUL_EN to make op 14 the low half of operA*operB.
module alu_mem_prog #(
    parameter int DMEM_AW = 7,
    parameter int PMEM_AW = 10
) (
    input logic          clk,
    input logic          rst,
    alu_mem_prog_if.slave bus
);
    localparam logic [31:0] NOP = 32'hF000_0000;

    logic [15:0] alu_res;
    logic [31:0] rom_word;
    logic [3:0]  sh;
    logic [15:0] mem [2**DMEM_AW];

    assign sh = bus.operB[3:0];

    always_comb begin
        alu_res = '0;
        case (bus.alu_op)
            4'd0:  alu_res = bus.operA + bus.operB;
            4'd1:  alu_res = bus.operA - bus.operB;
            4'd2:  alu_res = bus.operA & bus.operB;
            4'd3:  alu_res = bus.operA | bus.operB;
            4'd4:  alu_res = bus.operA ^ bus.operB;
            4'd5:  alu_res = ~bus.operA;
            4'd6:  alu_res = bus.operA << sh;
            4'd7:  alu_res = bus.operA >> sh;
            4'd8:  alu_res = unsigned'($signed(bus.operA) >>> sh);
            4'd9:  alu_res = bus.operA;
            4'd10: alu_res = bus.operB;
            4'd11: alu_res = bus.operA + 16'd1;
            4'd12: alu_res = bus.operA - 16'd1;
            4'd13: alu_res = {15'b0, bus.operA < bus.operB};
`ifdef ALU_MUL_EN
            4'd14: alu_res = bus.operA * bus.operB;
`else
            4'd14: alu_res = '0;
`endif
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        rom_word = NOP;
        case (bus.pc)
            PMEM_AW'(0): rom_word = 32'h8810_0005;
            PMEM_AW'(1): rom_word = 32'h8820_0003;
            PMEM_AW'(2): rom_word = 32'h1012_0000;
            PMEM_AW'(3): rom_word = 32'hC000_0000;
            default:     rom_word = NOP;
        endcase
    end

    // RAM contents survive reset; only the write is blocked while rst is low
    always_ff @(posedge clk) begin
        if (bus.we && rst)
            mem[bus.w_addr] <= bus.data_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.alu_out     <= '0;
            bus.data_out    <= '0;
            bus.instruction <= NOP;
        end else begin
            bus.alu_out     <= alu_res;
            bus.data_out    <= mem[bus.r_addr];
            bus.instruction <= rom_word;
        end
    end
endmodule

// File: tb/tb_alu_mem_prog.sv
// Scoreboard bench for alu_mem_prog: stimulus queues expectations,
// a monitor pops and compares them one cycle after each request.
module tb_alu_mem_prog;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t q[$];

`ifdef ALU_MUL_EN
    localparam logic [15:0] MUL_EXP = 16'h0100;
`else
    localparam logic [15:0] MUL_EXP = 16'h0000;
`endif

    alu_mem_prog_if #(.DMEM_AW(7), .PMEM_AW(10)) bus ();

    alu_mem_prog #(.DMEM_AW(7), .PMEM_AW(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin : monitor
        exp_t        e;
        logic [31:0] act;
        #1;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            case (e.sel)
                0:       act = {16'h0, bus.alu_out};
                1:       act = {16'h0, bus.data_out};
                default: act = bus.instruction;
            endcase
            checks++;
            if (act !== e.val || e.cyc != cyc) begin
                errors++;
                $display("FAIL %s (out %0d): got %h expected %h",
                         e.name, e.sel, act, e.val);
            end
        end
    end

    task automatic chk_now(input string nm, input logic [31:0] act,
                           input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // chk bits: [0] alu_out, [1] data_out, [2] instruction
    task automatic step(input string nm,
                        input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic w,
                        input logic [6:0] wa, input logic [15:0] din,
                        input logic [6:0] ra, input logic [9:0] p,
                        input logic [2:0] chk, input logic [15:0] ea,
                        input logic [15:0] ed, input logic [31:0] ei);
        @(negedge clk);
        bus.alu_op  = op;
        bus.operA   = a;
        bus.operB   = b;
        bus.we      = w;
        bus.w_addr  = wa;
        bus.data_in = din;
        bus.r_addr  = ra;
        bus.pc      = p;
        if (chk[0]) q.push_back('{cyc + 1, 0, {16'h0, ea}, nm});
        if (chk[1]) q.push_back('{cyc + 1, 1, {16'h0, ed}, nm});
        if (chk[2]) q.push_back('{cyc + 1, 2, ei, nm});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.alu_op  = '0;
        bus.operA   = '0;
        bus.operB   = '0;
        bus.we      = 1'b0;
        bus.w_addr  = '0;
        bus.data_in = '0;
        bus.r_addr  = '0;
        bus.pc      = '0;
        repeat (2) @(negedge clk);

        step("pre_wr", 4'd0, 16'h0001, 16'h0002, 1, 7'h10, 16'h5555,
             7'h00, 10'd0, 3'b101, 16'h0003, 16'h0, 32'h8810_0005);
        step("pre_rd", 4'd1, 16'h0003, 16'h0005, 0, 7'h00, 16'h0,
             7'h10, 10'd1, 3'b111, 16'hFFFE, 16'h5555, 32'h8820_0003);

        // asynchronous reset mid-run with a write pending
        @(negedge clk);
        bus.we      = 1'b1;
        bus.w_addr  = 7'h10;
        bus.data_in = 16'hDEAD;
        bus.r_addr  = 7'h10;
        #2 rst = 1'b0;
        #1;
        chk_now("rst_alu", {16'h0, bus.alu_out}, 32'h0);
        chk_now("rst_dout", {16'h0, bus.data_out}, 32'h0);
        chk_now("rst_instr", bus.instruction, 32'hF000_0000);
        @(posedge clk);
        @(negedge clk);
        chk_now("rst_hold_alu", {16'h0, bus.alu_out}, 32'h0);
        chk_now("rst_hold_instr", bus.instruction, 32'hF000_0000);
        bus.we = 1'b0;
        rst    = 1'b1;

        step("rst_wr_blocked", 4'd2, 16'hF0F0, 16'h3C3C, 0, 7'h00, 16'h0,
             7'h10, 10'd2, 3'b111, 16'h3030, 16'h5555, 32'h1012_0000);
        step("or_wr05", 4'd3, 16'hF0F0, 16'h0F0F, 1, 7'h05, 16'h1234,
             7'h00, 10'd3, 3'b101, 16'hFFFF, 16'h0, 32'hC000_0000);
        step("xor_rd05", 4'd4, 16'hFF00, 16'h0FF0, 0, 7'h00, 16'h0,
             7'h05, 10'd4, 3'b111, 16'hF0F0, 16'h1234, 32'hF000_0000);
        step("not_rw05", 4'd5, 16'h00FF, 16'h0000, 1, 7'h05, 16'hABCD,
             7'h05, 10'h3FF, 3'b111, 16'hFF00, 16'h1234, 32'hF000_0000);
        step("shl_rd05", 4'd6, 16'h0001, 16'h0013, 0, 7'h05, 16'h9999,
             7'h05, 10'd0, 3'b111, 16'h0008, 16'hABCD, 32'h8810_0005);
        step("shr_wr7f", 4'd7, 16'h8000, 16'h0004, 1, 7'h7F, 16'h1111,
             7'h05, 10'd1, 3'b111, 16'h0800, 16'hABCD, 32'h8820_0003);
        step("sra_wr00", 4'd8, 16'h8000, 16'h0004, 1, 7'h00, 16'h2222,
             7'h05, 10'd2, 3'b101, 16'hF800, 16'h0, 32'h1012_0000);
        step("shr_hi_rd7f", 4'd7, 16'h8000, 16'h00F4, 0, 7'h00, 16'h0,
             7'h7F, 10'd3, 3'b111, 16'h0800, 16'h1111, 32'hC000_0000);
        step("passa_rd00", 4'd9, 16'hABCD, 16'h0000, 0, 7'h00, 16'h0,
             7'h00, 10'd4, 3'b111, 16'hABCD, 16'h2222, 32'hF000_0000);
        step("passb_rd10", 4'd10, 16'h0000, 16'h4321, 0, 7'h00, 16'h0,
             7'h10, 10'd0, 3'b011, 16'h4321, 16'h5555, 32'h0);
        step("inc_wrap", 4'd11, 16'hFFFF, 16'h0000, 0, 7'h00, 16'h0,
             7'h00, 10'd0, 3'b001, 16'h0000, 16'h0, 32'h0);
        step("dec_wrap", 4'd12, 16'h0000, 16'h0000, 0, 7'h00, 16'h0,
             7'h00, 10'd0, 3'b001, 16'hFFFF, 16'h0, 32'h0);
        step("lt_true", 4'd13, 16'h0003, 16'h0005, 0, 7'h00, 16'h0,
             7'h00, 10'd0, 3'b001, 16'h0001, 16'h0, 32'h0);
        step("lt_false", 4'd13, 16'h0005, 16'h0003, 0, 7'h00, 16'h0,
             7'h00, 10'd0, 3'b001, 16'h0000, 16'h0, 32'h0);
        step("add_wrap", 4'd0, 16'hFFFF, 16'h0001, 0, 7'h00, 16'h0,
             7'h00, 10'd0, 3'b001, 16'h0000, 16'h0, 32'h0);
        step("zero_op", 4'd15, 16'h1234, 16'h5678, 0, 7'h00, 16'h0,
             7'h00, 10'd0, 3'b001, 16'h0000, 16'h0, 32'h0);
        step("mul_op", 4'd14, 16'h0100, 16'h0101, 0, 7'h00, 16'h0,
             7'h00, 10'd0, 3'b001, MUL_EXP, 16'h0, 32'h0);
        step("sub_b", 4'd1, 16'h1000, 16'h0001, 0, 7'h00, 16'h0,
             7'h05, 10'd0, 3'b011, 16'h0FFF, 16'hABCD, 32'h0);

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
